// File: rtl/equeue_int_pkg.sv
// Shared defaults and entry layout for the integer/mult/div issue queues.
package equeue_int_pkg;

    localparam int DEPTH_DEF  = 4;
    localparam int W_DATA_DEF = 32;
    localparam int W_TAG_DEF  = 6;
    localparam int W_OP_DEF   = 4;

    typedef struct packed {
        logic                  valid;
        logic [W_OP_DEF-1:0]   opcode;
        logic [W_TAG_DEF-1:0]  rdtag;
        logic [W_TAG_DEF-1:0]  rstag;
        logic [W_DATA_DEF-1:0] rsdata;
        logic                  rsvalid;
        logic [W_TAG_DEF-1:0]  rttag;
        logic [W_DATA_DEF-1:0] rtdata;
        logic                  rtvalid;
    } equeue_entry_t;

endpackage

// File: rtl/equeue_entry_snoop.sv
// One source operand compared against the CDB; yields the woken valid/data pair.
module equeue_entry_snoop
    import equeue_int_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEF,
    parameter int W_TAG  = W_TAG_DEF
) (
    input  logic              en,
    input  logic              src_valid,
    input  logic [W_TAG-1:0]  src_tag,
    input  logic [W_DATA-1:0] src_data,
    input  logic              cdb_valid,
    input  logic [W_TAG-1:0]  cdb_tag,
    input  logic [W_DATA-1:0] cdb_data,
    output logic              out_valid,
    output logic [W_DATA-1:0] out_data
);

    logic hit;

    assign hit       = en && !src_valid && cdb_valid && (cdb_tag == src_tag);
    assign out_valid = src_valid || hit;
    assign out_data  = hit ? cdb_data : src_data;

endmodule

// File: rtl/equeue_int.sv
// Integer-ALU issue queue: age-ordered, compacting, CDB-snooping.
// Define EQUEUEINT_ASSERT_EN to enable simulation-only protocol checks.
module equeue_int
    import equeue_int_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int W_DATA = W_DATA_DEF,
    parameter int W_TAG  = W_TAG_DEF,
    parameter int W_OP   = W_OP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W_OP-1:0]   dispatch_opcode,
    input  logic              dispatch_en,
    output logic              dispatch_ready,
    input  logic [W_TAG-1:0]  dispatch_rdtag,
    input  logic [W_TAG-1:0]  dispatch_rstag,
    input  logic [W_TAG-1:0]  dispatch_rttag,
    input  logic [W_DATA-1:0] dispatch_rsdata,
    input  logic [W_DATA-1:0] dispatch_rtdata,
    input  logic              dispatch_rsvalid,
    input  logic              dispatch_rtvalid,
    input  logic [W_TAG-1:0]  cdb_tag,
    input  logic              cdb_valid,
    input  logic [W_DATA-1:0] cdb_data,
    output logic [W_OP-1:0]   issueint_opcode,
    output logic [W_TAG-1:0]  issueint_rdtag,
    output logic [W_DATA-1:0] issueint_rsdata,
    output logic [W_DATA-1:0] issueint_rtdata,
    output logic              issueint_ready,
    input  logic              issueint_done
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [W_OP-1:0]   opcode;
        logic [W_TAG-1:0]  rdtag;
        logic [W_TAG-1:0]  rstag;
        logic [W_DATA-1:0] rsdata;
        logic              rsvalid;
        logic [W_TAG-1:0]  rttag;
        logic [W_DATA-1:0] rtdata;
        logic              rtvalid;
    } entry_t;

    entry_t            q     [DEPTH];
    entry_t            s     [DEPTH+1];
    entry_t            nxt   [DEPTH];
    entry_t            d_new;
    logic              rs_v  [DEPTH];
    logic              rt_v  [DEPTH];
    logic [W_DATA-1:0] rs_d  [DEPTH];
    logic [W_DATA-1:0] rt_d  [DEPTH];
    logic              dis_rs_v, dis_rt_v;
    logic [W_DATA-1:0] dis_rs_d, dis_rt_d;
    logic [CW-1:0]     count, count_nxt, tail_c;
    logic [IW-1:0]     sel_idx, tail;
    logic              sel_found, do_wr, do_rm;

    for (genvar i = 0; i < DEPTH; i++) begin : g_snoop
        equeue_entry_snoop #(.W_DATA(W_DATA), .W_TAG(W_TAG)) u_rs (
            .en(q[i].valid), .src_valid(q[i].rsvalid), .src_tag(q[i].rstag),
            .src_data(q[i].rsdata), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_data), .out_valid(rs_v[i]), .out_data(rs_d[i]));
        equeue_entry_snoop #(.W_DATA(W_DATA), .W_TAG(W_TAG)) u_rt (
            .en(q[i].valid), .src_valid(q[i].rtvalid), .src_tag(q[i].rttag),
            .src_data(q[i].rtdata), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_data), .out_valid(rt_v[i]), .out_data(rt_d[i]));
    end

    // Same-cycle bypass so a dispatched op never misses its producer's broadcast.
    equeue_entry_snoop #(.W_DATA(W_DATA), .W_TAG(W_TAG)) u_dis_rs (
        .en(1'b1), .src_valid(dispatch_rsvalid), .src_tag(dispatch_rstag),
        .src_data(dispatch_rsdata), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .out_valid(dis_rs_v), .out_data(dis_rs_d));
    equeue_entry_snoop #(.W_DATA(W_DATA), .W_TAG(W_TAG)) u_dis_rt (
        .en(1'b1), .src_valid(dispatch_rtvalid), .src_tag(dispatch_rttag),
        .src_data(dispatch_rtdata), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .out_valid(dis_rt_v), .out_data(dis_rt_d));

    always_comb begin
        d_new         = '0;
        d_new.valid   = 1'b1;
        d_new.opcode  = dispatch_opcode;
        d_new.rdtag   = dispatch_rdtag;
        d_new.rstag   = dispatch_rstag;
        d_new.rsdata  = dis_rs_d;
        d_new.rsvalid = dis_rs_v;
        d_new.rttag   = dispatch_rttag;
        d_new.rtdata  = dis_rt_d;
        d_new.rtvalid = dis_rt_v;
    end

    // Snooped view of every entry; s[DEPTH] is the empty slot shifted into the top.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            s[i]         = q[i];
            s[i].rsvalid = rs_v[i];
            s[i].rsdata  = rs_d[i];
            s[i].rtvalid = rt_v[i];
            s[i].rtdata  = rt_d[i];
        end
        s[DEPTH] = '0;
    end

    // Scan from the top so the lowest-index ready entry wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (q[i].valid && q[i].rsvalid && q[i].rtvalid) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign dispatch_ready = (count < CW'(DEPTH));
    assign do_wr          = dispatch_en && dispatch_ready;
    assign do_rm          = issueint_done && sel_found;

    always_comb begin
        count_nxt = count + CW'(do_wr) - CW'(do_rm);
        tail_c    = count - CW'(do_rm);
        tail      = tail_c[IW-1:0];
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = (do_rm && (i >= int'(sel_idx))) ? s[i+1] : s[i];
        end
        if (do_wr) begin
            nxt[tail] = d_new;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            count <= count_nxt;
            for (int i = 0; i < DEPTH; i++) q[i] <= nxt[i];
        end
    end

    always_comb begin
        issueint_ready  = sel_found;
        issueint_opcode = '0;
        issueint_rdtag  = '0;
        issueint_rsdata = '0;
        issueint_rtdata = '0;
        if (sel_found) begin
            issueint_opcode = q[sel_idx].opcode;
            issueint_rdtag  = q[sel_idx].rdtag;
            issueint_rsdata = q[sel_idx].rsdata;
            issueint_rtdata = q[sel_idx].rtdata;
        end
    end

`ifdef EQUEUEINT_ASSERT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            if (dispatch_en && !dispatch_ready)
                $error("equeue_int: dispatch_en asserted while queue full");
            if (issueint_done && !issueint_ready)
                $error("equeue_int: issueint_done asserted with nothing presented");
            if (count > CW'(DEPTH))
                $error("equeue_int: count %0d exceeds DEPTH", count);
        end
    end
`else
`endif

endmodule

// File: tb/tb_equeue_int.sv
// Directed scoreboard bench for equeue_int.
module tb_equeue_int;

    localparam int DEPTH  = 4;
    localparam int W_DATA = 32;
    localparam int W_TAG  = 6;
    localparam int W_OP   = 4;

    logic              clk;
    logic              reset;
    logic [W_OP-1:0]   dispatch_opcode;
    logic              dispatch_en;
    logic              dispatch_ready;
    logic [W_TAG-1:0]  dispatch_rdtag, dispatch_rstag, dispatch_rttag;
    logic [W_DATA-1:0] dispatch_rsdata, dispatch_rtdata;
    logic              dispatch_rsvalid, dispatch_rtvalid;
    logic [W_TAG-1:0]  cdb_tag;
    logic              cdb_valid;
    logic [W_DATA-1:0] cdb_data;
    logic [W_OP-1:0]   issueint_opcode;
    logic [W_TAG-1:0]  issueint_rdtag;
    logic [W_DATA-1:0] issueint_rsdata, issueint_rtdata;
    logic              issueint_ready;
    logic              issueint_done;

    typedef logic [W_OP+W_TAG+2*W_DATA-1:0] exp_t;
    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    equeue_int #(.DEPTH(DEPTH), .W_DATA(W_DATA), .W_TAG(W_TAG), .W_OP(W_OP)) dut (
        .clk(clk), .reset(reset),
        .dispatch_opcode(dispatch_opcode), .dispatch_en(dispatch_en),
        .dispatch_ready(dispatch_ready), .dispatch_rdtag(dispatch_rdtag),
        .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
        .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
        .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
        .cdb_tag(cdb_tag), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
        .issueint_opcode(issueint_opcode), .issueint_rdtag(issueint_rdtag),
        .issueint_rsdata(issueint_rsdata), .issueint_rtdata(issueint_rtdata),
        .issueint_ready(issueint_ready), .issueint_done(issueint_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        dispatch_en   = 1'b0;
        issueint_done = 1'b0;
        cdb_valid     = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [5:0] rd,
                        input logic rsv, input logic [5:0] rst, input logic [31:0] rsd,
                        input logic rtv, input logic [5:0] rtt, input logic [31:0] rtd);
        dispatch_en      = 1'b1;
        dispatch_opcode  = op;
        dispatch_rdtag   = rd;
        dispatch_rsvalid = rsv;
        dispatch_rstag   = rst;
        dispatch_rsdata  = rsd;
        dispatch_rtvalid = rtv;
        dispatch_rttag   = rtt;
        dispatch_rtdata  = rtd;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    task automatic push(input logic [3:0] op, input logic [5:0] rd,
                        input logic [31:0] rs, input logic [31:0] rt);
        sb.push_back({op, rd, rs, rt});
    endtask

    // Compare the presented entry against the scoreboard head and accept it.
    task automatic issue(input string tag);
        exp_t o;
        exp_t e;
        chk({tag, "_ready"}, issueint_ready, 1);
        o = {issueint_opcode, issueint_rdtag, issueint_rsdata, issueint_rtdata};
        chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(tag, o, e);
        end
        issueint_done = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        dispatch_en = 1'b0; issueint_done = 1'b0; cdb_valid = 1'b0;
        dispatch_opcode = '0; dispatch_rdtag = '0; dispatch_rstag = '0; dispatch_rttag = '0;
        dispatch_rsdata = '0; dispatch_rtdata = '0; dispatch_rsvalid = 1'b0; dispatch_rtvalid = 1'b0;
        cdb_tag = '0; cdb_data = '0;
        tick();
        tick();
        chk("rst_dispatch_ready", dispatch_ready, 1);
        chk("rst_issue_ready", issueint_ready, 0);
        chk("rst_issue_data", {issueint_opcode, issueint_rdtag, issueint_rsdata, issueint_rtdata}, 0);
        reset = 1'b1;
        tick();

        // Both operands valid at dispatch.
        disp(4'h2, 6'd5, 1'b1, 6'd0, 32'd10, 1'b1, 6'd0, 32'd20);
        push(4'h2, 6'd5, 32'd10, 32'd20);
        tick();
        issue("t1_issue");
        tick();
        chk("t1_empty_issue_ready", issueint_ready, 0);
        chk("t1_empty_dispatch_ready", dispatch_ready, 1);

        // Wakeup via CDB after dispatch.
        disp(4'h3, 6'd7, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd1);
        tick();
        chk("t2_not_ready", issueint_ready, 0);
        cdb(6'd3, 32'hAA);
        push(4'h3, 6'd7, 32'hAA, 32'd1);
        tick();
        issue("t2_wake_issue");
        tick();

        // Same-cycle dispatch bypass.
        disp(4'h4, 6'd8, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd2);
        cdb(6'd9, 32'h55);
        push(4'h4, 6'd8, 32'h55, 32'd2);
        tick();
        issue("t3_bypass_issue");
        tick();

        // Fill with waiting ops, then ignore an extra dispatch.
        for (int k = 0; k < DEPTH; k++) begin
            disp(4'(k + 5), 6'(10 + k), 1'b0, 6'(20 + k), 32'd0, 1'b1, 6'd0, 32'd0);
            tick();
        end
        chk("t4_full_dispatch_ready", dispatch_ready, 0);
        chk("t4_full_none_ready", issueint_ready, 0);
        disp(4'hF, 6'd14, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2);
        tick();
        chk("t4_extra_ignored", issueint_ready, 0);
        chk("t4_still_full", dispatch_ready, 0);
        cdb(6'd22, 32'h22);
        push(4'h7, 6'd12, 32'h22, 32'd0);
        tick();
        issue("t4_mid_issue");
        tick();
        chk("t4_space_after_issue", dispatch_ready, 1);
        cdb(6'd23, 32'h23);
        push(4'h8, 6'd13, 32'h23, 32'd0);
        tick();
        issue("t4_shifted_issue");
        tick();

        // Age priority: younger wakes first but older is issued first.
        cdb(6'd21, 32'h21);
        tick();
        chk("t5_young_presented", issueint_rdtag, 11);
        cdb(6'd20, 32'h20);
        push(4'h5, 6'd10, 32'h20, 32'd0);
        push(4'h6, 6'd11, 32'h21, 32'd0);
        tick();
        issue("t5_old_first");
        tick();
        issue("t5_young_second");
        tick();
        chk("t5_drained_ready", issueint_ready, 0);

        // Full queue with simultaneous remove and dispatch.
        disp(4'h9, 6'd30, 1'b1, 6'd0, 32'h30, 1'b1, 6'd0, 32'h31);
        push(4'h9, 6'd30, 32'h30, 32'h31);
        tick();
        for (int k = 0; k < DEPTH - 1; k++) begin
            disp(4'hA, 6'(31 + k), 1'b0, 6'(40 + k), 32'd0, 1'b1, 6'd0, 32'd0);
            tick();
        end
        chk("t6_full", dispatch_ready, 0);
        disp(4'hB, 6'd34, 1'b1, 6'd0, 32'h34, 1'b1, 6'd0, 32'h34);
        issue("t6_issue_when_full");
        tick();
        chk("t6_rejected_count3", dispatch_ready, 1);
        chk("t6_rejected_not_stored", issueint_ready, 0);
        disp(4'hC, 6'd35, 1'b1, 6'd0, 32'h35, 1'b1, 6'd0, 32'h36);
        push(4'hC, 6'd35, 32'h35, 32'h36);
        tick();
        chk("t6_refilled", dispatch_ready, 0);
        issue("t6_tail_issue");
        tick();
        chk("t6_after_tail_issue", dispatch_ready, 1);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
